// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between an instruction-fetch
// port and a data port; one transaction in flight, fixed MEM_LATENCY read delay.
module mem_arbiter #(
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_valid,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [3:0] LATENCY = 4'(MEM_LATENCY);
    localparam logic       PORT_IF = 1'b0;
    localparam logic       PORT_DM = 1'b1;

    state_t      state_reg, state_next;
    logic        last_grant_reg;
    logic        grant_reg;
    logic        we_reg;
    logic [3:0]  count_reg;
    logic [31:0] addr_reg, wdata_reg;
    logic [31:0] if_rdata_reg, dm_rdata_reg;
    logic        take;
    logic        pick;

    // Contention goes to the port that did not win last time.
    always_comb begin
        take = (state_reg == IDLE) && (if_req || dm_req);
        pick = PORT_IF;
        if (if_req && dm_req)
            pick = ~last_grant_reg;
        else if (dm_req)
            pick = PORT_DM;
    end

    always_comb begin
        state_next = state_reg;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        if_valid   = 1'b0;
        dm_valid   = 1'b0;
        case (state_reg)
            IDLE:    if (take) state_next = ISSUE;
            ISSUE: begin
                mem_en     = 1'b1;
                mem_we     = we_reg;
                state_next = WAIT;
            end
            WAIT:    if (count_reg == 4'd1) state_next = DONE;
            DONE: begin
                if_valid   = (grant_reg == PORT_IF);
                dm_valid   = (grant_reg == PORT_DM);
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            last_grant_reg <= PORT_IF;
            grant_reg      <= PORT_IF;
            we_reg         <= 1'b0;
            count_reg      <= 4'd0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            if_rdata_reg   <= '0;
            dm_rdata_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (take) begin
                grant_reg      <= pick;
                last_grant_reg <= pick;
                we_reg         <= pick & dm_we;
                addr_reg       <= pick ? dm_addr : if_addr;
                wdata_reg      <= pick ? dm_wdata : 32'd0;
            end
            if (state_reg == ISSUE)
                count_reg <= LATENCY;
            else if (state_reg == WAIT)
                count_reg <= count_reg - 4'd1;
            // Last WAIT cycle: read data is on mem_rdata now; stores capture nothing.
            if (state_reg == WAIT && count_reg == 4'd1 && !we_reg) begin
                if (grant_reg == PORT_DM)
                    dm_rdata_reg <= mem_rdata;
                else
                    if_rdata_reg <= mem_rdata;
            end
        end
    end

    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign if_rdata  = if_rdata_reg;
    assign dm_rdata  = dm_rdata_reg;
endmodule

// File: tb/tb_mem_arbiter.sv
// Drives three arbiters (latency 1, 2, 15) with shared stimulus; a transaction-timeline
// model predicts every output each cycle, and directed scenarios pin exact cycle numbers.
module tb_mem_arbiter;
    localparam int N = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic [31:0] mem_rdata [N];
    logic        mem_en [N], mem_we [N], if_valid [N], dm_valid [N];
    logic [31:0] mem_addr [N], mem_wdata [N], if_rdata [N], dm_rdata [N];

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_dut
            mem_arbiter #(.MEM_LATENCY((gi == 0) ? 1 : ((gi == 1) ? 2 : 15))) dut (
                .clk(clk), .reset(reset),
                .if_req(if_req), .if_addr(if_addr),
                .if_rdata(if_rdata[gi]), .if_valid(if_valid[gi]),
                .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
                .dm_rdata(dm_rdata[gi]), .dm_valid(dm_valid[gi]),
                .mem_en(mem_en[gi]), .mem_we(mem_we[gi]), .mem_addr(mem_addr[gi]),
                .mem_wdata(mem_wdata[gi]), .mem_rdata(mem_rdata[gi])
            );
        end
    endgenerate

    function automatic int lat_of(int m);
        return (m == 0) ? 1 : ((m == 1) ? 2 : 15);
    endfunction

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    task automatic chk(string name, int m, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s lat=%0d t=%0t: got %h expected %h", name, lat_of(m), $time, act, exp);
        end
    endtask

    // Model: per DUT, the transaction in flight and t = cycles since the grant edge.
    bit          m_busy [N];
    int          m_t    [N];
    bit          m_port [N];
    bit          m_we   [N];
    bit          m_last [N];
    logic [31:0] m_addr [N], m_wdata [N], m_if_rd [N], m_dm_rd [N];

    always @(negedge clk) begin
        for (int m = 0; m < N; m++) begin
            int  lat;
            bit  en;
            lat = lat_of(m);
            en  = m_busy[m] && m_t[m] == 1;
            chk("mem_en", m, 32'(mem_en[m]), 32'(en));
            chk("mem_we", m, 32'(mem_we[m]), 32'(en && m_we[m]));
            if (en) chk("mem_addr", m, mem_addr[m], m_addr[m]);
            if (en && m_we[m]) chk("mem_wdata", m, mem_wdata[m], m_wdata[m]);
            chk("if_valid", m, 32'(if_valid[m]), 32'(m_busy[m] && m_t[m] == lat + 2 && !m_port[m]));
            chk("dm_valid", m, 32'(dm_valid[m]), 32'(m_busy[m] && m_t[m] == lat + 2 && m_port[m]));
            chk("if_rdata", m, if_rdata[m], m_if_rd[m]);
            chk("dm_rdata", m, dm_rdata[m], m_dm_rd[m]);
            // What the coming edge does.
            if (reset) begin
                m_busy[m]  = 0;
                m_last[m]  = 0;
                m_if_rd[m] = '0;
                m_dm_rd[m] = '0;
            end else if (m_busy[m]) begin
                if (m_t[m] == lat + 1 && !m_we[m]) begin
                    if (m_port[m]) m_dm_rd[m] = mem_rdata[m];
                    else           m_if_rd[m] = mem_rdata[m];
                end
                if (m_t[m] == lat + 2) m_busy[m] = 0;
                else                   m_t[m]++;
            end else if (if_req || dm_req) begin
                m_port[m]  = (if_req && dm_req) ? !m_last[m] : dm_req;
                m_last[m]  = m_port[m];
                m_we[m]    = m_port[m] && dm_we;
                m_addr[m]  = m_port[m] ? dm_addr : if_addr;
                m_wdata[m] = dm_wdata;
                m_busy[m]  = 1;
                m_t[m]     = 1;
            end
        end
    end

    // Directed-scenario observation records.
    int          en_n [N], en_k [N], we_n [N], if_n [N], if_k [N], dm_n [N], dm_k [N];
    logic [31:0] en_addr [N], wd [N], if_rd [N], dm_rd [N];

    task automatic clear_obs();
        for (int m = 0; m < N; m++) begin
            en_n[m] = 0; en_k[m] = -1; we_n[m] = 0; if_n[m] = 0; if_k[m] = -1;
            dm_n[m] = 0; dm_k[m] = -1; en_addr[m] = 'x; wd[m] = 'x; if_rd[m] = 'x; dm_rd[m] = 'x;
        end
    endtask

    task automatic observe(int k);
        #3;
        for (int m = 0; m < N; m++) begin
            if (mem_en[m] === 1'b1) begin en_n[m]++; en_k[m] = k; en_addr[m] = mem_addr[m]; end
            if (mem_we[m] === 1'b1) begin we_n[m]++; wd[m] = mem_wdata[m]; end
            if (if_valid[m] === 1'b1) begin if_n[m]++; if_k[m] = k; if_rd[m] = if_rdata[m]; end
            if (dm_valid[m] === 1'b1) begin dm_n[m]++; dm_k[m] = k; dm_rd[m] = dm_rdata[m]; end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 0; dm_req = 0; dm_we = 0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0;
    endtask

    task automatic do_reset();
        reset = 1;
        idle_inputs();
        step();
        step();
        reset = 0;
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        for (int m = 0; m < N; m++) begin
            mem_rdata[m] = '0;
            m_busy[m] = 0; m_t[m] = 0; m_port[m] = 0; m_we[m] = 0; m_last[m] = 0;
            m_addr[m] = '0; m_wdata[m] = '0; m_if_rd[m] = '0; m_dm_rd[m] = '0;
        end
        step();
        step();

        // Single fetch of 0x10, request dropped right after the grant.
        do_reset();
        clear_obs();
        for (int k = 0; k <= 20; k++) begin
            if (k > 0) step();
            if_req  = (k == 0);
            if_addr = 32'h10;
            for (int m = 0; m < N; m++)
                mem_rdata[m] = (k == lat_of(m) + 1) ? 32'h00500093 : (32'hBAD00000 | 32'(k));
            observe(k);
        end
        for (int m = 0; m < N; m++) begin
            chk("fetch_issue_count", m, 32'(en_n[m]), 32'd1);
            chk("fetch_issue_cycle", m, 32'(en_k[m]), 32'd1);
            chk("fetch_addr", m, en_addr[m], 32'h10);
            chk("fetch_valid_count", m, 32'(if_n[m]), 32'd1);
            chk("fetch_valid_cycle", m, 32'(if_k[m]), (m == 0) ? 32'd3 : ((m == 1) ? 32'd4 : 32'd17));
            chk("fetch_rdata", m, if_rd[m], 32'h00500093);
        end

        // Both requests pending right after reset: DM load first, then IF.
        do_reset();
        clear_obs();
        for (int k = 0; k <= 25; k++) begin
            if (k > 0) step();
            dm_req  = (k <= 4);
            dm_we   = 0;
            dm_addr = 32'h40;
            if_req  = (k <= 9);
            if_addr = 32'h80;
            for (int m = 0; m < N; m++) mem_rdata[m] = 32'hC0DE0000 | 32'(k);
            observe(k);
        end
        chk("rr_dm_valid_cycle", 1, 32'(dm_k[1]), 32'd4);
        chk("rr_if_issue_cycle", 1, 32'(en_k[1]), 32'd6);
        chk("rr_if_valid_cycle", 1, 32'(if_k[1]), 32'd9);
        chk("rr_dm_rdata", 1, dm_rd[1], 32'hC0DE0003);
        chk("rr_if_rdata", 1, if_rd[1], 32'hC0DE0008);

        // Store aborted by reset in WAIT, then a store served normally.
        do_reset();
        clear_obs();
        for (int k = 0; k <= 25; k++) begin
            if (k > 0) step();
            reset    = (k == 2);
            dm_req   = (k == 0 || k == 5);
            dm_we    = 1;
            dm_addr  = 32'h20;
            dm_wdata = 32'hDEADBEEF;
            for (int m = 0; m < N; m++) mem_rdata[m] = 32'h5A5A0000 | 32'(k);
            observe(k);
        end
        for (int m = 0; m < N; m++) begin
            chk("store_valid_count", m, 32'(dm_n[m]), 32'd1);
            chk("store_valid_cycle", m, 32'(dm_k[m]), 32'(lat_of(m) + 7));
            chk("store_we_count", m, 32'(we_n[m]), 32'd2);
            chk("store_wdata", m, wd[m], 32'hDEADBEEF);
            chk("store_dm_rdata", m, dm_rd[m], 32'h0);
        end
        idle_inputs();

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 4000; c++) begin
            step();
            reset    = ($urandom_range(0, 199) == 0);
            if_req   = ($urandom_range(0, 99) < 60);
            dm_req   = ($urandom_range(0, 99) < 60);
            dm_we    = $urandom_range(0, 1);
            if_addr  = $urandom;
            dm_addr  = $urandom;
            dm_wdata = $urandom;
            begin
                logic [31:0] r;
                r = $urandom;
                for (int m = 0; m < N; m++) mem_rdata[m] = r;
            end
        end
        step();
        idle_inputs();
        reset = 0;
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
